// File: rtl/mc_controller_fsm.sv
// Multicycle MIPS control FSM with a mem_ready handshake and a memory wait-timeout counter.
// Build macro CTRL_TRAP_EN: illegal opcodes and memory timeouts divert through a TRAP state.
module mc_controller_fsm #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               BranchNe,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               ALUSrcA,
   output logic [1:0]         PCSource,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal_op,
   output logic               mem_timeout,
   output logic [3:0]         state_o
);

   typedef enum logic [3:0] {
      INIT   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MADDR  = 4'd3,
      MEMLW  = 4'd4,
      MEMR   = 4'd5,
      MEMSW  = 4'd6,
      EXEC   = 4'd7,
      RCOMP  = 4'd8,
      IMMEX  = 4'd9,
      IMMWB  = 4'd10,
      BRANCH = 4'd11,
      JUMP   = 4'd12,
      TRAP   = 4'd13
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'd0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'd1);
   localparam logic [ALUOP_W-1:0] ALU_RF  = ALUOP_W'(3'd2);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'd3);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'd4);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'd5);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

`ifdef CTRL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   state_t               state;
   state_t               next_state;
   logic [CNT_W-1:0]     wait_cnt;
   logic [CNT_W-1:0]     next_cnt;
   logic [ALUOP_W-1:0]   imm_aluop;
   logic [ALUOP_W-1:0]   dec_aluop;
   logic                 branch_ne;
   logic                 waiting;
   logic                 timeout_hit;
   logic                 dec_illegal;

   // Wait-state detection, timeout detection and wait counter update
   always_comb begin
      waiting     = (state == FETCH) || (state == MEMLW) || (state == MEMSW);
      timeout_hit = 1'b0;
      next_cnt    = {CNT_W{1'b0}};
      if (MEM_TIMEOUT != 0) begin
         timeout_hit = waiting && !mem_ready && (wait_cnt == TO_LAST);
         if (waiting && !mem_ready && !timeout_hit) begin
            next_cnt = wait_cnt + CNT_W'(1);
         end else begin
            next_cnt = {CNT_W{1'b0}};
         end
      end else begin
         timeout_hit = 1'b0;
         next_cnt    = {CNT_W{1'b0}};
      end
   end

   // Immediate-group ALU operation, latched in DECODE so IMMEX/IMMWB ignore the opcode
   always_comb begin
      dec_aluop = ALU_ADD;
      case (opcode)
         OP_ANDI: dec_aluop = ALU_AND;
         OP_ORI:  dec_aluop = ALU_OR;
         OP_SLTI: dec_aluop = ALU_SLT;
         default: dec_aluop = ALU_ADD;
      endcase
   end

   // Next-state logic
   always_comb begin
      next_state  = state;
      dec_illegal = 1'b0;
      case (state)
         INIT:  next_state = FETCH;
         FETCH: begin
            if (mem_ready) begin
               next_state = DECODE;
            end else if (TRAP_EN && timeout_hit) begin
               next_state = TRAP;
            end else begin
               next_state = FETCH;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW:                      next_state = MADDR;
               OP_R:                              next_state = EXEC;
               OP_BEQ, OP_BNE:                    next_state = BRANCH;
               OP_J:                              next_state = JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = IMMEX;
               default: begin
                  dec_illegal = 1'b1;
                  next_state  = TRAP_EN ? TRAP : FETCH;
               end
            endcase
         end
         MADDR: begin
            case (opcode)
               OP_LW:   next_state = MEMLW;
               OP_SW:   next_state = MEMSW;
               default: next_state = FETCH;
            endcase
         end
         MEMLW: begin
            if (mem_ready) begin
               next_state = MEMR;
            end else if (TRAP_EN && timeout_hit) begin
               next_state = TRAP;
            end else begin
               next_state = MEMLW;
            end
         end
         MEMSW: begin
            if (mem_ready) begin
               next_state = FETCH;
            end else if (TRAP_EN && timeout_hit) begin
               next_state = TRAP;
            end else begin
               next_state = MEMSW;
            end
         end
         EXEC:   next_state = RCOMP;
         IMMEX:  next_state = IMMWB;
         MEMR, RCOMP, IMMWB, BRANCH, JUMP, TRAP: next_state = FETCH;
         default: next_state = INIT;
      endcase
   end

   // State, wait counter and decode-time captures
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         wait_cnt  <= {CNT_W{1'b0}};
         imm_aluop <= ALU_ADD;
         branch_ne <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;
         if (state == DECODE) begin
            imm_aluop <= dec_aluop;
            branch_ne <= (opcode == OP_BNE);
         end
      end
   end

   // Datapath controls; FETCH and MEMSW write strobes are gated by mem_ready
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = ALU_ADD;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         DECODE: ALUSrcB = 2'b11;
         MADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMLW: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMR: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMSW: begin
            IorD     = 1'b1;
            MemWrite = mem_ready;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_RF;
         end
         RCOMP: begin
            ALUSrcA  = 1'b1;
            ALUOp    = ALU_RF;
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         IMMEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = imm_aluop;
         end
         IMMWB: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = 2'b10;
            ALUOp    = imm_aluop;
            RegWrite = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCSource    = 2'b01;
            PCWriteCond = 1'b1;
            BranchNe    = branch_ne;
         end
         JUMP: begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
         end
         TRAP: begin
            PCSource = 2'b11;
            PCWrite  = 1'b1;
         end
         default: PCWrite = 1'b0;
      endcase
   end

   assign illegal_op  = (state == DECODE) && dec_illegal;
   assign mem_timeout = timeout_hit;
   assign state_o     = state;

endmodule

// File: tb/tb_mc_controller_fsm.sv
// Randomized self-checking bench for mc_controller_fsm against an instruction-level phase model.
// Honours CTRL_TRAP_EN the same way as the design build.
module tb_mc_controller_fsm;

   localparam int TB_TO = 4;

`ifdef CTRL_TRAP_EN
   localparam bit TRAP_BUILD = 1'b1;
`else
   localparam bit TRAP_BUILD = 1'b0;
`endif

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef enum int {
      PH_FETCH, PH_DECODE, PH_ADDR, PH_LOAD, PH_LOADWB, PH_STORE,
      PH_RTYPE, PH_RTYPEWB, PH_IMM, PH_IMMWB, PH_BRANCH, PH_JUMP, PH_TRAP
   } phase_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, RegWrite, RegDst, ALUSrcA, illegal_op, mem_timeout;
   logic [1:0] PCSource, ALUSrcB;
   logic [2:0] ALUOp;
   logic [3:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;
   int n_cyc = 0;

   always #5 clk = ~clk;

   mc_controller_fsm #(.ALUOP_W(3), .MEM_TIMEOUT(TB_TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .state_o(state_o)
   );

   wire [19:0] obs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
                      IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp,
                      illegal_op, mem_timeout};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit legal(input logic [5:0] op);
      return op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
   endfunction

   function automatic logic [2:0] imm_alu(input logic [5:0] op);
      if (op == OP_ANDI) return 3'b011;
      else if (op == OP_ORI) return 3'b100;
      else if (op == OP_SLTI) return 3'b101;
      else return 3'b000;
   endfunction

   // Expected control word for one phase of an instruction (mem_timeout bit left 0)
   function automatic logic [19:0] ctl(input phase_t ph, input logic [5:0] op, input logic rdy);
      logic pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rdst, srca, ill;
      logic [1:0] pcs, srcb;
      logic [2:0] aop;
      {pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rdst, srca, ill} = 12'd0;
      pcs = 2'b00; srcb = 2'b00; aop = 3'b000;
      case (ph)
         PH_FETCH:   begin mrd = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         PH_DECODE:  begin srcb = 2'b11; ill = !legal(op); end
         PH_ADDR:    begin srca = 1'b1; srcb = 2'b10; end
         PH_LOAD:    begin mrd = 1'b1; iord = 1'b1; end
         PH_LOADWB:  begin rw = 1'b1; m2r = 1'b1; end
         PH_STORE:   begin iord = 1'b1; mwr = rdy; end
         PH_RTYPE:   begin srca = 1'b1; aop = 3'b010; end
         PH_RTYPEWB: begin srca = 1'b1; aop = 3'b010; rdst = 1'b1; rw = 1'b1; end
         PH_IMM:     begin srca = 1'b1; srcb = 2'b10; aop = imm_alu(op); end
         PH_IMMWB:   begin srca = 1'b1; srcb = 2'b10; aop = imm_alu(op); rw = 1'b1; end
         PH_BRANCH:  begin srca = 1'b1; aop = 3'b001; pcs = 2'b01; pcwc = 1'b1; bne = (op == OP_BNE); end
         PH_JUMP:    begin pcs = 2'b10; pcw = 1'b1; end
         PH_TRAP:    begin pcs = 2'b11; pcw = 1'b1; end
         default:    aop = 3'b000;
      endcase
      return {pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rdst, srca, pcs, srcb, aop, ill, 1'b0};
   endfunction

   task automatic step(input phase_t ph, input logic [5:0] op, input logic rdy, input logic to);
      mem_ready = rdy;
      @(negedge clk);
      check_val($sformatf("%s/op%b/rdy%b", ph.name(), op, rdy), {12'd0, obs},
                {12'd0, ctl(ph, op, rdy) | {19'd0, to}});
      n_cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      check_val("init_outputs", {12'd0, obs}, 32'd0);
      check_val("init_state", {28'd0, state_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Run one instruction from FETCH; fixed_wait < 0 picks random wait lengths
   task automatic run_instr(input logic [5:0] op, input int fixed_wait);
      phase_t q[$];
      phase_t ph;
      int w, idle;
      logic r, to;
      bit done;
      opcode = op;
      q.push_back(PH_FETCH);
      q.push_back(PH_DECODE);
      if (op == OP_LW) begin
         q.push_back(PH_ADDR); q.push_back(PH_LOAD); q.push_back(PH_LOADWB);
      end else if (op == OP_SW) begin
         q.push_back(PH_ADDR); q.push_back(PH_STORE);
      end else if (op == OP_R) begin
         q.push_back(PH_RTYPE); q.push_back(PH_RTYPEWB);
      end else if (op == OP_BEQ || op == OP_BNE) begin
         q.push_back(PH_BRANCH);
      end else if (op == OP_J) begin
         q.push_back(PH_JUMP);
      end else if (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI}) begin
         q.push_back(PH_IMM); q.push_back(PH_IMMWB);
      end else if (TRAP_BUILD) begin
         q.push_back(PH_TRAP);
      end
      while (q.size() != 0) begin
         ph = q.pop_front();
         if (ph inside {PH_FETCH, PH_LOAD, PH_STORE}) begin
            w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(6, 0));
            idle = 0;
            done = 1'b0;
            while (!done) begin
               r  = (idle == w);
               to = !r && (((idle + 1) % TB_TO) == 0);
               step(ph, op, r, to);
               if (r) begin
                  done = 1'b1;
               end else begin
                  idle++;
                  if (to && TRAP_BUILD) begin
                     q.delete();
                     q.push_back(PH_TRAP);
                     done = 1'b1;
                  end
               end
            end
         end else begin
            step(ph, op, 1'($urandom_range(1, 0)), 1'b0);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      logic [5:0] op;
      logic [5:0] ops [10] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};

      #2;
      check_val("rst_outputs", {12'd0, obs}, 32'd0);
      check_val("rst_state", {28'd0, state_o}, 32'd0);
      release_reset();

      // async reset in the middle of a load's memory wait
      opcode = OP_LW;
      step(PH_FETCH, OP_LW, 1'b1, 1'b0);
      step(PH_DECODE, OP_LW, 1'b0, 1'b0);
      step(PH_ADDR, OP_LW, 1'b0, 1'b0);
      mem_ready = 1'b0;
      @(negedge clk);
      check_val("memlw_before_rst", {12'd0, obs}, {12'd0, ctl(PH_LOAD, OP_LW, 1'b0)});
      #2;
      rst = 1'b1;
      #1;
      check_val("midrst_outputs", {12'd0, obs}, 32'd0);
      check_val("midrst_state", {28'd0, state_o}, 32'd0);
      release_reset();

      c0 = n_cyc;
      run_instr(OP_LW, 3);
      check_val("lw_wait3_cycles", n_cyc - c0, (TB_TO > 4) ? 11 : 11);
      c0 = n_cyc;
      run_instr(OP_R, 0);
      check_val("r_latency", n_cyc - c0, 4);
      c0 = n_cyc;
      run_instr(OP_SW, 0);
      check_val("sw_latency", n_cyc - c0, 4);
      run_instr(OP_BNE, 0);
      run_instr(OP_BEQ, 0);
      c0 = n_cyc;
      run_instr(OP_ORI, 0);
      check_val("imm_latency", n_cyc - c0, 4);
      run_instr(OP_J, 0);
      run_instr(OP_ANDI, 1);
      run_instr(OP_SLTI, 2);
      run_instr(OP_SW, 5);
      run_instr(OP_J, 9);
      run_instr(6'b111111, 0);
      run_instr(OP_LW, 9);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(7, 0) == 0) begin
            op = 6'($urandom);
         end else begin
            op = ops[$urandom_range(9, 0)];
         end
         run_instr(op, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
